gate_checker: RTL and testbench
===============================

GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 The module SHALL have parameter NUM_VECTORS, default 16, meaning the test vectors per run (1..65535).
REQ-002 The module SHALL have parameter SETTLE_CYCLES, default 2, meaning the wait cycles between drive and sample (1..255).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The module SHALL have port start, input, 1 bit: a run request, sampled only in IDLE.
REQ-006 The module SHALL have port drive_a, output, 1 bit: the stimulus to the inverter-under-test input.
REQ-007 The module SHALL have port sense_b, input, 1 bit: the inverter-under-test output, synchronous to clk.
REQ-008 The module SHALL have port busy, output, 1 bit: high while a run is in progress.
REQ-009 The module SHALL have port done, output, 1 bit: a one-cycle pulse at end of run.
REQ-010 The module SHALL have port pass, output, 1 bit: 1 when the last run had zero errors.
REQ-011 The module SHALL have port err_count, output, 8 bits: the mismatch count, saturating.

Function
REQ-012 The FSM SHALL have states IDLE, DRIVE, SETTLE, SAMPLE and DONE.
REQ-013 In IDLE, start=1 SHALL move to DRIVE and clear err_count, the vector counter and pass; the LFSR SHALL be reloaded with seed 8'hA5.
REQ-014 In DRIVE, drive_a SHALL load lfsr[0] and the settle counter SHALL load SETTLE_CYCLES, then the FSM SHALL go to SETTLE.
REQ-015 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then the FSM SHALL go to SAMPLE.
REQ-016 In SAMPLE, if sense_b != ~drive_a, err_count SHALL increment, holding at 8'hFF with no wrap.
REQ-017 In SAMPLE, when vector counter = NUM_VECTORS-1 the FSM SHALL go to DONE; otherwise the counter SHALL increment, the LFSR SHALL step, and the FSM SHALL go to DRIVE.
REQ-018 The LFSR SHALL shift left with feedback bit = l[7]^l[5]^l[4]^l[3], stepping only in SAMPLE.
REQ-019 Each vector SHALL take SETTLE_CYCLES+2 cycles; done SHALL assert 1 + NUM_VECTORS*(SETTLE_CYCLES+2) cycles after the start-sampling edge.
REQ-020 In DONE, done=1 for one cycle and pass SHALL be set to (err_count==0), then the FSM SHALL return to IDLE.
REQ-021 pass and err_count SHALL hold their values until the next accepted start.
REQ-022 busy SHALL be 1 in DRIVE, SETTLE and SAMPLE, and 0 in IDLE and DONE.
REQ-023 start while not in IDLE SHALL be ignored and SHALL have no effect on the run in progress.
REQ-024 drive_a SHALL hold its value from DRIVE until the next DRIVE or reset.

Reset
REQ-025 On rst_n=0, at any time including mid-run, the module SHALL go to IDLE with drive_a=0, busy=0, done=0, pass=0, err_count=0, vector counter=0 and LFSR=8'hA5.
REQ-026 On rst_n release, the first accepted start SHALL begin a fresh run with no residual state.

Configuration
REQ-027 Macro GATE_CHECKER_FIRST_FAIL_EN, when defined, SHALL add outputs first_fail_valid (1 bit) and first_fail_idx (16 bits).
REQ-028 With GATE_CHECKER_FIRST_FAIL_EN defined, these outputs SHALL capture the vector index of the first mismatch in a run, and SHALL be cleared on an accepted start and on reset.
REQ-029 Without GATE_CHECKER_FIRST_FAIL_EN, these ports and registers SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 Package gate_checker_pkg SHALL hold the state enum, LFSR_SEED (8'hA5), the LFSR tap constants and ERR_MAX (8'hFF).
REQ-031 The LFSR SHALL be a sub-module lfsr8 with ports clk, rst_n, load, step, seed and q.

Verification
REQ-032 Ideal inverter with defaults: start pulse -> done exactly 65 cycles later, pass=1, err_count=0.
REQ-033 Buffer in place of inverter (sense_b=drive_a): err_count=16, pass=0; with the macro defined, first_fail_valid=1 and first_fail_idx=0.
REQ-034 Buffer with NUM_VECTORS=300: err_count=8'hFF (saturated), pass=0, done after 1201 cycles.
REQ-035 sense_b stuck at 0: err_count SHALL equal the count of drive_a=0 vectors from the reference LFSR model; a start pulse mid-run SHALL leave done timing unchanged.
REQ-036 rst_n low at vector 7: all outputs SHALL reach reset values immediately; the next start SHALL give the same drive_a sequence as the first run, beginning 1.

Source files
------------

// File: rtl/gate_checker_pkg.sv
// Shared types and constants for the gate_checker inverter test sequencer.
// Optional first-fail capture is enabled by defining GATE_CHECKER_FIRST_FAIL_EN.
package gate_checker_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps at bits 7, 5, 4 and 3 form the feedback XOR.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;
  localparam logic [7:0] ERR_MAX   = 8'hFF;

  function automatic logic lfsr_fb(input logic [7:0] l);
    return ^(l & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/gate_checker_lfsr8.sv
// 8-bit left-shifting Fibonacci LFSR with synchronous load and step enables.
module lfsr8
  import gate_checker_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed;
    end else if (step) begin
      q_d = {q_q[6:0], lfsr_fb(q_q)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= LFSR_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/gate_checker.sv
// Drives LFSR patterns into an inverter-under-test and counts output mismatches.
// Define GATE_CHECKER_FIRST_FAIL_EN to add first-mismatch index capture outputs.
module gate_checker
  import gate_checker_pkg::*;
#(
  parameter int NUM_VECTORS   = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       drive_a,
  input  logic       sense_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count
`ifdef GATE_CHECKER_FIRST_FAIL_EN
  ,
  output logic        first_fail_valid,
  output logic [15:0] first_fail_idx
`endif
);

  state_t      state_q, state_d;
  logic        drive_q, drive_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [7:0]  err_q, err_d;
  logic [15:0] vec_q, vec_d;
  logic [7:0]  settle_q, settle_d;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
  logic        ffv_q, ffv_d;
  logic [15:0] ffi_q, ffi_d;
`endif

  logic [7:0] lfsr_q;
  logic       lfsr_load, lfsr_step;
  logic       last_vec, mismatch;
  // Only the LSB of the LFSR is used as stimulus.
  logic       lfsr_unused;

  assign last_vec    = (vec_q == 16'(NUM_VECTORS - 1));
  assign mismatch    = (sense_b != ~drive_q);
  assign lfsr_load   = (state_q == IDLE) && start;
  assign lfsr_step   = (state_q == SAMPLE) && !last_vec;
  assign lfsr_unused = ^lfsr_q[7:1];

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  always_comb begin
    state_d  = state_q;
    drive_d  = drive_q;
    pass_d   = pass_q;
    err_d    = err_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    done_d   = 1'b0;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    ffv_d    = ffv_q;
    ffi_d    = ffi_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          err_d   = 8'h00;
          vec_d   = 16'h0000;
          pass_d  = 1'b0;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
          ffv_d   = 1'b0;
          ffi_d   = 16'h0000;
`endif
        end
      end
      DRIVE: begin
        drive_d  = lfsr_q[0];
        settle_d = 8'(SETTLE_CYCLES);
        state_d  = SETTLE;
      end
      SETTLE: begin
        settle_d = settle_q - 8'd1;
        if (settle_q == 8'd1) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + 8'd1;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = vec_q;
          end
`endif
        end
        if (last_vec) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 16'd1;
          state_d = DRIVE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_q == 8'h00);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == DRIVE) || (state_d == SETTLE) || (state_d == SAMPLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      drive_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= 8'h00;
      vec_q    <= 16'h0000;
      settle_q <= 8'h00;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
      ffv_q    <= 1'b0;
      ffi_q    <= 16'h0000;
`endif
    end else begin
      state_q  <= state_d;
      drive_q  <= drive_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
      ffv_q    <= ffv_d;
      ffi_q    <= ffi_d;
`endif
    end
  end

  assign drive_a   = drive_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;
`endif

endmodule

// File: tb/tb_gate_checker.sv
// Scoreboard bench for gate_checker: stimulus queues expected results, a monitor checks them.
module tb_gate_checker;

  typedef struct {
    int unsigned start_cyc;
    int unsigned lat;
    logic        pass;
    logic [7:0]  err;
    logic        ffv;
    logic [15:0] ffi;
  } exp_t;

  logic clk, rst_n, start, start2;
  logic drive_a, sense_b, busy, done, pass;
  logic [7:0] err_count;
  logic drive_a2, sense_b2, busy2, done2, pass2;
  logic [7:0] err_count2;
`ifdef GATE_CHECKER_FIRST_FAIL_EN
  logic ffv1, ffv2;
  logic [15:0] ffi1, ffi2;
`endif

  int mode = 0;
  int unsigned cyc = 0;
  int unsigned run_start = 0;
  int reset_req = 0;
  int reset_seen = 0;
  int total = 0;
  int bad = 0;
  exp_t sb1[$];
  exp_t sb2[$];
  logic exp_drv[$];
  logic model_bits[16];

  assign sense_b  = (mode == 0) ? ~drive_a : (mode == 1) ? drive_a : 1'b0;
  assign sense_b2 = drive_a2;

  gate_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .drive_a(drive_a), .sense_b(sense_b),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count)
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    , .first_fail_valid(ffv1), .first_fail_idx(ffi1)
`endif
  );

  gate_checker #(.NUM_VECTORS(300), .SETTLE_CYCLES(2)) dut_big (
    .clk(clk), .rst_n(rst_n), .start(start2), .drive_a(drive_a2), .sense_b(sense_b2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2)
`ifdef GATE_CHECKER_FIRST_FAIL_EN
    , .first_fail_valid(ffv2), .first_fail_idx(ffi2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: the only process that compares and steps the counters.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset_req != reset_seen) begin
      reset_seen = reset_req;
      chk("rst_drive_a", int'(drive_a), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_pass", int'(pass), 0);
      chk("rst_err", int'(err_count), 0);
`ifdef GATE_CHECKER_FIRST_FAIL_EN
      chk("rst_ffv", int'(ffv1), 0);
`endif
    end
    if (busy && (((cyc - run_start) % 4) == 2)) begin
      if (exp_drv.size() == 0) chk("drv_unexpected", 1, 0);
      else chk("drive_a_seq", int'(drive_a), int'(exp_drv.pop_front()));
    end
    if (done) begin
      if (sb1.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        e = sb1.pop_front();
        chk("done_latency", int'(cyc - e.start_cyc), int'(e.lat));
        chk("pass", int'(pass), int'(e.pass));
        chk("err_count", int'(err_count), int'(e.err));
`ifdef GATE_CHECKER_FIRST_FAIL_EN
        chk("first_fail_valid", int'(ffv1), int'(e.ffv));
        if (e.ffv) chk("first_fail_idx", int'(ffi1), int'(e.ffi));
`endif
      end
    end else if (sb1.size() != 0 && cyc > sb1[0].start_cyc + sb1[0].lat + 4) begin
      void'(sb1.pop_front());
      chk("done_timeout", 1, 0);
    end
    if (done2) begin
      if (sb2.size() == 0) chk("done2_unexpected", 1, 0);
      else begin
        e = sb2.pop_front();
        chk("big_latency", int'(cyc - e.start_cyc), int'(e.lat));
        chk("big_pass", int'(pass2), int'(e.pass));
        chk("big_err_count", int'(err_count2), int'(e.err));
`ifdef GATE_CHECKER_FIRST_FAIL_EN
        chk("big_first_fail_valid", int'(ffv2), int'(e.ffv));
        chk("big_first_fail_idx", int'(ffi2), int'(e.ffi));
`endif
      end
    end else if (sb2.size() != 0 && cyc > sb2[0].start_cyc + sb2[0].lat + 4) begin
      void'(sb2.pop_front());
      chk("done2_timeout", 1, 0);
    end
  end

  // Starts a 16-vector run on dut; m: 0 inverter, 1 buffer, 2 sense stuck at 0.
  task automatic kick(input int m, input int ndrv, input bit want_done);
    exp_t e;
    int zeros, first_zero;
    zeros = 0;
    first_zero = 0;
    for (int k = 15; k >= 0; k--) begin
      if (!model_bits[k]) begin
        zeros++;
        first_zero = k;
      end
    end
    mode = m;
    @(negedge clk);
    start = 1'b1;
    run_start = cyc + 1;
    for (int k = 0; k < ndrv; k++) exp_drv.push_back(model_bits[k]);
    if (want_done) begin
      e.start_cyc = cyc + 1;
      e.lat = 65;
      e.err = (m == 0) ? 8'd0 : (m == 1) ? 8'd16 : 8'(zeros);
      e.pass = (e.err == 8'd0);
      e.ffv = (e.err != 8'd0);
      e.ffi = (m == 1) ? 16'd0 : 16'(first_zero);
      sb1.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_sb1();
    while (sb1.size() != 0) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    exp_t e;
    logic [7:0] l;
    l = 8'hA5;
    for (int k = 0; k < 16; k++) begin
      model_bits[k] = l[0];
      l = lfsr_next(l);
    end
    rst_n = 1'b0;
    start = 1'b0;
    start2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_req++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    kick(0, 16, 1'b1);
    wait_sb1();
    kick(1, 16, 1'b1);
    wait_sb1();
    kick(2, 16, 1'b1);
    while (cyc < run_start + 20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_sb1();

    // Buffered run interrupted by reset during vector 7.
    kick(1, 8, 1'b0);
    while (cyc < run_start + 30) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    reset_req++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    kick(0, 16, 1'b1);
    wait_sb1();

    @(negedge clk);
    start2 = 1'b1;
    e.start_cyc = cyc + 1;
    e.lat = 1201;
    e.pass = 1'b0;
    e.err = 8'hFF;
    e.ffv = 1'b1;
    e.ffi = 16'd0;
    sb2.push_back(e);
    @(negedge clk);
    start2 = 1'b0;
    while (sb2.size() != 0) @(negedge clk);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
